// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, Funct3 access codes,
// byte-lane count and the alignment rule used by the optional misalignment trap.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANES = 4;

  // Halves must sit on even addresses; words (including reserved codes) on multiples of 4.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [LANES-1:0]      mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for a new access,
// plus lane extraction and sign/zero extension of the returned load word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_addr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] ld_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be    = '1;
    wdata = wr_data;
    case (st_funct3[1:0])
      F3_B[1:0]: begin
        be    = LANES'(1) << st_addr_lo;
        wdata = {4{wr_data[7:0]}};
      end
      F3_H[1:0]: begin
        be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wr_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Reserved Funct3 codes fall through to a full-word load.
  always_comb begin
    byte_sel = rd_data[{ld_addr_lo, 3'b000} +: 8];
    half_sel = ld_addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'h0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'h0, half_sel};
      F3_W:    ld_data = rd_data;
      default: ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE/REQ/DONE handshake with ack timeout and core stall.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int TIMEOUT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] Addr,
  input  logic [DATA_W-1:0]     WrData,
  output logic [DATA_W-1:0]     ReadData,
  output logic                  Stall,
  output logic                  Err,
  lsu_if.master                 bus
);
  // The counter value seen in the final allowed REQ cycle (limit - 1, counting from zero).
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

  state_t                state, state_next;
  logic [TIMEOUT_W-1:0]  cnt;
  logic [2:0]            f3_q;
  logic [1:0]            lo_q;
  logic                  err_q;
  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [LANES-1:0]      be_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [LANES-1:0]      be_c;
  logic [DATA_W-1:0]     wdata_c;
  logic [DATA_W-1:0]     load_c;
  logic                  start;
  logic                  trap;
  logic                  timeout;

  assign start = MemRead | MemWrite;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(Funct3, Addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // An ack arriving in the last allowed cycle wins over the timeout.
  assign timeout = (state == REQ) && !bus.mem_ack && (cnt == CNT_LAST);

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_funct3  (Funct3),
    .st_addr_lo (Addr[1:0]),
    .wr_data    (WrData),
    .be         (be_c),
    .wdata      (wdata_c),
    .ld_funct3  (f3_q),
    .ld_addr_lo (lo_q),
    .rd_data    (bus.mem_rdata),
    .ld_data    (load_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = trap ? DONE : REQ;
      REQ:     if (bus.mem_ack || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req = 1'b0;
    Stall       = 1'b0;
    Err         = 1'b0;
    case (state)
      IDLE:    Stall = start & ~reset;
      REQ: begin
        bus.mem_req = 1'b1;
        Stall       = 1'b1;
      end
      DONE:    Err = err_q;
      default: ;
    endcase
  end

  // Access attributes are frozen at issue so the bus sees stable values for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      f3_q     <= '0;
      lo_q     <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      ReadData <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q    <= MemWrite;
          addr_q  <= {Addr[DM_ADDRESS-1:2], 2'b00};
          be_q    <= be_c;
          wdata_q <= wdata_c;
          f3_q    <= Funct3;
          lo_q    <= Addr[1:0];
          cnt     <= '0;
          err_q   <= trap;
          if (trap) ReadData <= '0;
        end
        REQ: begin
          if (bus.mem_ack) begin
            err_q <= 1'b0;
            if (!we_q) ReadData <= load_c;
          end else if (timeout) begin
            err_q    <= 1'b1;
            ReadData <= '0;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the datapath's memory-stage signals (ALU address, rs2 data, Funct3, MemRead/MemWrite) and a handshaked data-memory bus. Converts byte/half/word accesses into word-aligned bus transactions with byte enables, sign/zero-extends load data, and stalls the core until the bus acknowledges. Its ReadData output feeds the register-file write-back mux in place of the single-cycle data memory.

## Interface
Parameters:
- DATA_W, 32, data width; fixed at 32 (4 byte lanes)
- DM_ADDRESS, 9, byte address width
- TIMEOUT_W, 4, ack-timeout counter width; limit = 2^TIMEOUT_W − 1 cycles

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- MemRead  in  1  load requested (level, from control)
- MemWrite  in  1  store requested (level, from control)
- Funct3  in  3  access size/sign
- Addr  in  DM_ADDRESS  byte address (ALUResult low bits)
- WrData  in  DATA_W  store data (rs2)
- ReadData  out  DATA_W  extended load result
- Stall  out  1  freeze PC and register file
- Err  out  1  one-cycle error pulse
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  DM_ADDRESS  word-aligned byte address, low 2 bits 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_W  lane-replicated store data
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion

## Operation
- FSM: IDLE, REQ, DONE.
- IDLE: if MemRead|MemWrite, register mem_we (= MemWrite; MemWrite wins if both set), mem_addr, mem_be, mem_wdata, Funct3, Addr[1:0]; clear timeout counter; go REQ. Stall = MemRead|MemWrite (combinational) in IDLE.
- REQ: mem_req=1, Stall=1. mem_ack → capture extracted load data into ReadData, go DONE. Counter reaching limit without ack → mem_req drops, ReadData=0, Err=1 in DONE.
- DONE: Stall=0, ReadData holds, instruction retires; unconditionally → IDLE. Prevents re-issuing the same access while MemRead/MemWrite is still high.
- Byte enables: Funct3[1:0]=00 → 1<<Addr[1:0]; 01 → Addr[1] ? 1100 : 0011; else 1111.
- Store data: SB {4{WrData[7:0]}}, SH {2{WrData[15:0]}}, SW WrData.
- Load: select lane by Addr[1:0]; 000 LB sign-ext, 100 LBU zero-ext, 001 LH sign-ext, 101 LHU zero-ext, 010 LW; reserved 011/110/111 treated as word.
- Stores leave ReadData unchanged.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, ReadData 0, Err 0; Stall forced 0 while reset is high.
- Min access: 3 cycles (IDLE sample, REQ with same-cycle ack, DONE), core stalled 2 cycles.
- Each extra wait cycle before mem_ack adds one stall cycle.
- Bus rules: mem_addr/mem_be/mem_we/mem_wdata stable for the whole time mem_req=1. mem_ack is ignored outside REQ. Ack on the same cycle the limit is reached counts as success.
- Reset mid-REQ: mem_req drops asynchronously and the access is abandoned. The bus must tolerate the abort.
- Err high only in DONE, exactly one cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half access with Addr[0]=1 or word access with Addr[1:0]≠0 issues no bus request. IDLE → DONE directly, Err=1, ReadData=0, one stall cycle.
- Undefined: no check. Low address bits are dropped to the aligned lane, the access proceeds, and Err comes from timeout only.

## Structure
- Package lsu_pkg: state enum (IDLE/REQ/DONE); Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU); lane-count constant.
- Sub-module lsu_align (combinational): computes byte enables, replicated write data, and the extracted/extended load value. The FSM, counter and registers stay in load_store_unit.

## Test plan
- LW at Addr 0x010, mem_rdata=0xDEADBEEF, ack in first REQ cycle → mem_addr 0x010, be 1111, ReadData 0xDEADBEEF in DONE, Stall high exactly 2 cycles.
- LB at 0x013, rdata 0x80FF_0000 → be 1000, ReadData 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x022, WrData 0x1234ABCD, ack after 3 wait cycles → mem_we 1, be 1100, wdata 0xABCDABCD, Stall high 5 cycles, ReadData unchanged.
- No ack for 15 REQ cycles (TIMEOUT_W=4) → mem_req drops, Err pulse 1 cycle, ReadData 0, FSM back in IDLE.
- LW at 0x012 with LSU_MISALIGN_TRAP_EN → mem_req never asserts, Err=1 next cycle. Without the macro → mem_addr 0x010, be 1111.
- Reset asserted in REQ cycle 2 → mem_req 0 immediately, all outputs at reset values. After reset release with MemRead high → a fresh access starts.
